layer_output_serializer: RTL and testbench
==========================================

// Module: layer_output_serializer
// PURPOSE
//   Sequences one neuron layer into the next. Collects the per-neuron results of a layer
//   (one parallel word per neuron, each with its own valid) into a capture buffer.
//   Once every neuron has reported, it replays the words one per cycle on the serial
//   x_in/x_valid input of the following layer. A second frame may accumulate while the
//   previous one is being replayed.
// PARAMETERS
//   NN         10   neurons in the source layer = words per frame (>=2)
//   dataWidth  16   bits per neuron output word
// PORTS
//   clk        in   1              single clock; all state updates on rising edge
//   rst        in   1              synchronous, active-high reset
//   flush      in   1              synchronous clear of buffer and shifter; overrun kept
//   i_valid    in   NN             per-neuron result valid (bit k = neuron k)
//   i_data     in   NN*dataWidth   neuron k word at [k*dataWidth +: dataWidth]
//   o_valid    out  1              serial word valid, drives next layer x_valid
//   o_data     out  dataWidth      serial word, drives next layer x_in
//   o_last     out  1              high with the word of neuron NN-1
//   busy       out  1              capture mask non-zero OR shifter active
//   overrun    out  1              sticky: duplicate result for a neuron in an incomplete frame
// BEHAVIOUR
//   Reset values: o_valid=0, o_data=0, o_last=0, busy=0, overrun=0.
//     Capture mask, capture buffer, shift counter and state also clear.
//   Capture
//     - At each edge, for every k with i_valid[k]=1 and mask[k]=0: cap[k] <= i_data slice k,
//       and mask[k] <= 1.
//     - i_valid[k]=1 with mask[k]=1, and no transfer on this edge:
//       data discarded (first value kept) and overrun <= 1.
//   Transfer
//     - Condition: mask all-ones AND (state==IDLE OR shifter is emitting its last word).
//     - On that edge: load shift buffer from cap, mask <= 0, state <= SHIFT, cnt <= 0.
//     - Same-edge capture: i_valid bits arriving on the transfer edge are accepted into the
//       new, empty mask (next frame). They are not overruns.
//       mask_next = (xfer ? 0 : mask) | accepted.
//   FSM: IDLE, SHIFT.
//     - IDLE -> SHIFT on transfer.
//     - SHIFT: o_valid=1, o_data=word[cnt], cnt increments each cycle.
//     - At cnt==NN-1: o_last=1. If a transfer is pending, reload and stay in SHIFT
//       (back-to-back frames, no bubble). Otherwise go to IDLE.
//   Latency
//     - Last outstanding i_valid bit sampled at edge E.
//     - mask is full in the cycle after E; the transfer occurs at the following edge.
//     - Neuron 0 word appears on o_valid two cycles after E.
//     - NN consecutive valid words follow, neuron 0 first.
//   Outputs are registered. o_data holds its last value when o_valid=0.
//   Width: cnt is $clog2(NN) bits and never wraps past NN-1.
//   Boundaries
//     - Partial frames wait indefinitely; there is no timeout.
//     - Mask full while SHIFT not at its last word: buffer holds, further i_valid counts as
//       overrun.
//     - flush: mask<=0, state<=IDLE, o_valid<=0, o_last<=0. flush wins over capture and
//       transfer on the same edge.
//     - rst mid-frame: all state returns to reset values on that edge; o_valid=0 next cycle.
// STRUCTURE
//   Shared package nn_pkg:
//     - FSM state enum {IDLE, SHIFT}
//     - default dataWidth constant, also used by the neuron layers
//   One sub-module is natural: word_shifter (NN-word load/emit buffer with cnt and o_last).
//   Capture mask, overrun and transfer logic stay in the top.
// TESTING   (NN=4, dataWidth=16)
//   1. i_valid=4'hF, i_data=64'h0004_0003_0002_0001 at edge E
//      -> o_data 1,2,3,4 on cycles E+2..E+5, o_last only at E+5, busy falls after E+5.
//   2. Staggered: bits {0,2} at E, bit 1 at E+3, bit 3 at E+5
//      -> first word at E+7, order neuron 0..3, overrun=0.
//   3. Frame B (data 0xB0..0xB3) completes while frame A is shifting
//      -> 8 consecutive o_valid cycles, A then B, o_last on the 4th and 8th.
//   4. Bit 1 arrives twice (0x11, then 0x22) before frame complete
//      -> overrun=1 and sticky; replay carries 0x11 for neuron 1.
//   5. rst asserted on 2nd word of replay
//      -> o_valid=0 next cycle, overrun=0, a subsequent full frame replays normally.
//   6. flush with mask=4'b0101
//      -> next frame needs all 4 bits again, overrun unchanged.

Source files
------------

// File: rtl/nn_pkg.sv
// Types and constants shared by the neuron layers and the inter-layer serializer.
package nn_pkg;

    localparam int unsigned DataWidth = 16;

    typedef enum logic {
        StIdle,
        StShift
    } state_e;

endpackage

// File: rtl/word_shifter.sv
// NN-word load/emit buffer: loads a whole frame in one edge, then emits one registered
// word per cycle with o_last on the final word.
module word_shifter
    import nn_pkg::*;
#(
    parameter int unsigned NN        = 10,
    parameter int unsigned dataWidth = DataWidth
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    load,
    input  logic [NN*dataWidth-1:0] load_data,
    output logic                    ready,
    output logic                    active,
    output logic                    o_valid,
    output logic [dataWidth-1:0]    o_data,
    output logic                    o_last
);

    localparam int unsigned CntW = $clog2(NN);

    state_e                 state_q, state_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic [dataWidth-1:0]   buf_q [NN];
    logic [dataWidth-1:0]   buf_d [NN];
    logic                   o_valid_q, o_valid_d;
    logic                   o_last_q, o_last_d;
    logic [dataWidth-1:0]   o_data_q, o_data_d;
    logic                   last_word;

    assign last_word = (state_q == StShift) && (cnt_q == CntW'(NN - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            buf_q     <= '{default: '0};
            o_valid_q <= 1'b0;
            o_last_q  <= 1'b0;
            o_data_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            buf_q     <= buf_d;
            o_valid_q <= o_valid_d;
            o_last_q  <= o_last_d;
            o_data_q  <= o_data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        if (flush) begin
            state_d = StIdle;
            cnt_d   = '0;
            buf_d   = '{default: '0};
        end else if (load) begin
            // A load on the last word reloads in place, giving gap-free back-to-back frames.
            state_d = StShift;
            cnt_d   = '0;
            for (int k = 0; k < NN; k++) begin
                buf_d[k] = load_data[k*dataWidth +: dataWidth];
            end
        end else if (state_q == StShift) begin
            if (last_word) begin
                state_d = StIdle;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    always_comb begin
        o_valid_d = !flush && (state_q == StShift);
        o_last_d  = !flush && last_word;
        o_data_d  = o_valid_d ? buf_q[cnt_q] : o_data_q;
    end

    assign ready   = (state_q == StIdle) || last_word;
    assign active  = (state_q == StShift) || o_valid_q;
    assign o_valid = o_valid_q;
    assign o_data  = o_data_q;
    assign o_last  = o_last_q;

endmodule

// File: rtl/layer_output_serializer.sv
// Collects one result word per neuron into a capture buffer and, once the frame is complete,
// hands it to the word shifter for serial replay into the next layer.
module layer_output_serializer
    import nn_pkg::*;
#(
    parameter int unsigned NN        = 10,
    parameter int unsigned dataWidth = DataWidth
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic [NN-1:0]           i_valid,
    input  logic [NN*dataWidth-1:0] i_data,
    output logic                    o_valid,
    output logic [dataWidth-1:0]    o_data,
    output logic                    o_last,
    output logic                    busy,
    output logic                    overrun
);

    logic [NN-1:0]           mask_q, mask_d;
    logic [NN*dataWidth-1:0] cap_q, cap_d;
    logic                    overrun_q, overrun_d;
    logic [NN-1:0]           mask_cur, accepted, dup;
    logic                    sh_ready, sh_active, xfer;

    always_ff @(posedge clk) begin
        if (rst) begin
            mask_q    <= '0;
            cap_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            mask_q    <= mask_d;
            cap_q     <= cap_d;
            overrun_q <= overrun_d;
        end
    end

    always_comb begin
        xfer     = !flush && (&mask_q) && sh_ready;
        // On a transfer edge the mask is already empty for the next frame, so nothing duplicates.
        mask_cur = xfer ? '0 : mask_q;
        accepted = i_valid & ~mask_cur;
        dup      = i_valid & mask_cur;

        cap_d = cap_q;
        for (int k = 0; k < NN; k++) begin
            if (accepted[k]) begin
                cap_d[k*dataWidth +: dataWidth] = i_data[k*dataWidth +: dataWidth];
            end
        end

        mask_d    = mask_cur | accepted;
        overrun_d = overrun_q | ((|dup) && !flush);

        if (flush) begin
            mask_d = '0;
            cap_d  = '0;
        end
    end

    word_shifter #(
        .NN        (NN),
        .dataWidth (dataWidth)
    ) u_word_shifter (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .load      (xfer),
        .load_data (cap_q),
        .ready     (sh_ready),
        .active    (sh_active),
        .o_valid   (o_valid),
        .o_data    (o_data),
        .o_last    (o_last)
    );

    assign busy    = (|mask_q) || sh_active;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_layer_output_serializer.sv
// Directed bench for layer_output_serializer with NN=4, dataWidth=16.
module tb_layer_output_serializer;

    localparam int unsigned NN = 4;
    localparam int unsigned DW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic [NN-1:0] i_valid;
    logic [63:0]   i_data;
    logic          o_valid;
    logic [DW-1:0] o_data;
    logic          o_last;
    logic          busy;
    logic          overrun;

    int n_checks = 0;
    int n_fail   = 0;

    layer_output_serializer #(
        .NN        (NN),
        .dataWidth (DW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .i_valid (i_valid),
        .i_data  (i_data),
        .o_valid (o_valid),
        .o_data  (o_data),
        .o_last  (o_last),
        .busy    (busy),
        .overrun (overrun)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_word(input string tag, input logic v, input logic [15:0] d,
                               input logic l);
        check({tag, ".valid"}, {31'd0, o_valid}, {31'd0, v});
        if (v) check({tag, ".data"}, {16'd0, o_data}, {16'd0, d});
        check({tag, ".last"}, {31'd0, o_last}, {31'd0, l});
    endtask

    initial begin
        rst     = 1'b1;
        flush   = 1'b0;
        i_valid = '0;
        i_data  = '0;
        step();
        step();
        check("rst.o_valid", {31'd0, o_valid}, 32'd0);
        check("rst.o_data", {16'd0, o_data}, 32'd0);
        check("rst.o_last", {31'd0, o_last}, 32'd0);
        check("rst.busy", {31'd0, busy}, 32'd0);
        check("rst.overrun", {31'd0, overrun}, 32'd0);
        rst = 1'b0;
        step();

        // 1: full frame in one edge
        i_valid = 4'hF;
        i_data  = 64'h0004_0003_0002_0001;
        step();                                   // E
        i_valid = '0;
        check("t1.busy_e", {31'd0, busy}, 32'd1);
        expect_word("t1.e0", 1'b0, 16'h0, 1'b0);
        step();                                   // E+1
        expect_word("t1.e1", 1'b0, 16'h0, 1'b0);
        step(); expect_word("t1.w0", 1'b1, 16'h0001, 1'b0);
        step(); expect_word("t1.w1", 1'b1, 16'h0002, 1'b0);
        step(); expect_word("t1.w2", 1'b1, 16'h0003, 1'b0);
        step(); expect_word("t1.w3", 1'b1, 16'h0004, 1'b1);
        check("t1.busy_w3", {31'd0, busy}, 32'd1);
        step();
        expect_word("t1.end", 1'b0, 16'h0, 1'b0);
        check("t1.hold", {16'd0, o_data}, 32'h0004);
        check("t1.busy_end", {31'd0, busy}, 32'd0);

        // 2: staggered arrival
        i_data  = 64'h0023_0022_0021_0020;
        i_valid = 4'b0101;
        step();                                   // E
        i_valid = '0;
        step();
        step();
        i_valid = 4'b0010;
        step();                                   // E+3
        i_valid = '0;
        step();
        i_valid = 4'b1000;
        step();                                   // E+5
        i_valid = '0;
        expect_word("t2.e5", 1'b0, 16'h0, 1'b0);
        step(); expect_word("t2.e6", 1'b0, 16'h0, 1'b0);
        step(); expect_word("t2.w0", 1'b1, 16'h0020, 1'b0);
        step(); expect_word("t2.w1", 1'b1, 16'h0021, 1'b0);
        step(); expect_word("t2.w2", 1'b1, 16'h0022, 1'b0);
        step(); expect_word("t2.w3", 1'b1, 16'h0023, 1'b1);
        check("t2.overrun", {31'd0, overrun}, 32'd0);
        step();
        expect_word("t2.end", 1'b0, 16'h0, 1'b0);

        // 3: frame B collected while frame A shifts, part of it on the transfer edge
        i_data  = 64'h00A3_00A2_00A1_00A0;
        i_valid = 4'hF;
        step();                                   // E
        i_data  = 64'h00B3_00B2_00B1_00B0;
        i_valid = 4'b0011;
        step();                                   // E+1: transfer of A
        i_valid = 4'b1100;
        step(); expect_word("t3.a0", 1'b1, 16'h00A0, 1'b0);
        i_valid = '0;
        step(); expect_word("t3.a1", 1'b1, 16'h00A1, 1'b0);
        step(); expect_word("t3.a2", 1'b1, 16'h00A2, 1'b0);
        step(); expect_word("t3.a3", 1'b1, 16'h00A3, 1'b1);
        step(); expect_word("t3.b0", 1'b1, 16'h00B0, 1'b0);
        step(); expect_word("t3.b1", 1'b1, 16'h00B1, 1'b0);
        step(); expect_word("t3.b2", 1'b1, 16'h00B2, 1'b0);
        step(); expect_word("t3.b3", 1'b1, 16'h00B3, 1'b1);
        check("t3.overrun", {31'd0, overrun}, 32'd0);
        step();
        expect_word("t3.end", 1'b0, 16'h0, 1'b0);
        check("t3.busy_end", {31'd0, busy}, 32'd0);

        // 4: duplicate result for neuron 1
        i_data  = 64'h0043_0042_0011_0040;
        i_valid = 4'b0010;
        step();
        check("t4.no_ovr_yet", {31'd0, overrun}, 32'd0);
        i_data  = 64'h0043_0042_0022_0040;
        step();
        check("t4.ovr_set", {31'd0, overrun}, 32'd1);
        i_valid = 4'b1101;
        step();                                   // frame complete
        i_valid = '0;
        step();
        step(); expect_word("t4.w0", 1'b1, 16'h0040, 1'b0);
        step(); expect_word("t4.w1", 1'b1, 16'h0011, 1'b0);
        step(); expect_word("t4.w2", 1'b1, 16'h0042, 1'b0);
        step(); expect_word("t4.w3", 1'b1, 16'h0043, 1'b1);
        step();
        check("t4.ovr_sticky", {31'd0, overrun}, 32'd1);

        // 5: reset during replay
        i_data  = 64'h0053_0052_0051_0050;
        i_valid = 4'hF;
        step();
        i_valid = '0;
        step();
        step(); expect_word("t5.w0", 1'b1, 16'h0050, 1'b0);
        step(); expect_word("t5.w1", 1'b1, 16'h0051, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        expect_word("t5.rst", 1'b0, 16'h0, 1'b0);
        check("t5.rst_data", {16'd0, o_data}, 32'd0);
        check("t5.rst_ovr", {31'd0, overrun}, 32'd0);
        check("t5.rst_busy", {31'd0, busy}, 32'd0);
        step();
        expect_word("t5.after", 1'b0, 16'h0, 1'b0);
        i_data  = 64'h0057_0056_0055_0054;
        i_valid = 4'hF;
        step();
        i_valid = '0;
        step();
        step(); expect_word("t5.n0", 1'b1, 16'h0054, 1'b0);
        step(); expect_word("t5.n1", 1'b1, 16'h0055, 1'b0);
        step(); expect_word("t5.n2", 1'b1, 16'h0056, 1'b0);
        step(); expect_word("t5.n3", 1'b1, 16'h0057, 1'b1);
        step();

        // 6: flush with a partial mask, overrun must survive
        i_data  = 64'h0063_0062_0061_0060;
        i_valid = 4'b0101;
        step();
        i_valid = 4'b0001;
        step();
        check("t6.ovr_set", {31'd0, overrun}, 32'd1);
        i_valid = 4'b0010;
        flush   = 1'b1;
        step();
        flush   = 1'b0;
        i_valid = '0;
        check("t6.busy_flush", {31'd0, busy}, 32'd0);
        check("t6.ovr_kept", {31'd0, overrun}, 32'd1);
        i_valid = 4'b1010;
        step();
        i_valid = '0;
        step();
        step();
        expect_word("t6.partial", 1'b0, 16'h0, 1'b0);
        check("t6.busy_partial", {31'd0, busy}, 32'd1);
        i_data  = 64'h0073_0072_0071_0070;
        i_valid = 4'b0101;
        step();
        i_valid = '0;
        step();
        step(); expect_word("t6.w0", 1'b1, 16'h0070, 1'b0);
        step(); expect_word("t6.w1", 1'b1, 16'h0061, 1'b0);
        step(); expect_word("t6.w2", 1'b1, 16'h0072, 1'b0);
        step(); expect_word("t6.w3", 1'b1, 16'h0063, 1'b1);
        check("t6.ovr_end", {31'd0, overrun}, 32'd1);
        step();
        expect_word("t6.end", 1'b0, 16'h0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
